// File: rtl/wait_match_pkg.sv
// Shared types and helpers for the wait_match_trigger channels.
package wait_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REARM = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Hold counter needs at least one bit even when HOLD == 1.
  function automatic int hold_cnt_w(input int hold);
    return (clog2(hold) < 1) ? 1 : clog2(hold);
  endfunction

endpackage

// File: rtl/wait_match_chan.sv
// One channel: waits for enable && value == match, latches load, then holds off.
module wait_match_chan
  import wait_match_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] match,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] result,
  output logic             fire,
  output logic             busy,
  output logic [CNT_W-1:0] fire_count
);

  localparam int HW = hold_cnt_w(HOLD);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

  state_e           state_q;
  logic [HW-1:0]    hold_q;
  logic [WIDTH-1:0] result_q;
  logic             fire_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cond;

  assign cond = enable && (value == match);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      result_q <= '0;
      fire_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fire_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cond) begin
            result_q <= load;
            fire_q   <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= cnt_d;
            hold_q   <= HOLD_INIT;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= mode ? ST_REARM : ST_IDLE;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        ST_REARM: begin
          if (!cond) state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign result     = result_q;
  assign fire       = fire_q;
  assign busy       = busy_q;
  assign fire_count = cnt_q;

endmodule

// File: rtl/wait_match_trigger.sv
// Multi-channel wait-on-match trigger: slices the flattened buses per channel.
module wait_match_trigger
  import wait_match_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD     = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] value,
  input  logic [CHANNELS*WIDTH-1:0] match,
  input  logic [CHANNELS*WIDTH-1:0] load,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic [CHANNELS-1:0]       fire,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] fire_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    wait_match_chan #(
      .WIDTH (WIDTH),
      .HOLD  (HOLD),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear[i]),
      .mode       (mode[i]),
      .enable     (enable[i]),
      .value      (value[i*WIDTH +: WIDTH]),
      .match      (match[i*WIDTH +: WIDTH]),
      .load       (load[i*WIDTH +: WIDTH]),
      .result     (result[i*WIDTH +: WIDTH]),
      .fire       (fire[i]),
      .busy       (busy[i]),
      .fire_count (fire_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_wait_match_trigger.sv
// Scoreboard bench for wait_match_trigger: per-cycle expected outputs from a behavioural model.
module tb_wait_match_trigger;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int HD = 3;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*W-1:0] value, match, load, result;
  logic [CH-1:0]   mode, enable, clear, fire, busy;
  logic [CH*CW-1:0] fire_count;

  wait_match_trigger #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .HOLD     (HD),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .match      (match),
    .load       (load),
    .mode       (mode),
    .enable     (enable),
    .clear      (clear),
    .result     (result),
    .fire       (fire),
    .busy       (busy),
    .fire_count (fire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*W-1:0]  res;
    logic [CH-1:0]    fire;
    logic [CH-1:0]    busy;
    logic [CH*CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model: busy_left counts remaining busy cycles, wait_drop marks "must see cond low first".
  int m_res[CH], m_cnt[CH], m_left[CH];
  bit m_fire[CH], m_wait[CH];
  int tally_fire[CH], tally_busy[CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   cond;
    for (int i = 0; i < CH; i++) begin
      cond = enable[i] && (value[i*W +: W] == match[i*W +: W]);
      if (reset || clear[i]) begin
        m_res[i] = 0; m_cnt[i] = 0; m_left[i] = 0; m_fire[i] = 0; m_wait[i] = 0;
      end else if (m_left[i] > 0) begin
        m_fire[i] = 0;
        m_left[i]--;
        if (m_left[i] == 0 && mode[i]) m_wait[i] = 1;
      end else if (m_wait[i]) begin
        m_fire[i] = 0;
        if (!cond) m_wait[i] = 0;
      end else if (cond) begin
        m_res[i]  = int'(load[i*W +: W]);
        m_fire[i] = 1;
        if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
        m_left[i] = HD;
      end else begin
        m_fire[i] = 0;
      end
      e.res[i*W +: W]   = W'(m_res[i]);
      e.fire[i]         = m_fire[i];
      e.busy[i]         = (m_left[i] > 0);
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("res%0d", i),  32'(result[i*W +: W]),      32'(e.res[i*W +: W]));
      check($sformatf("fire%0d", i), 32'(fire[i]),               32'(e.fire[i]));
      check($sformatf("busy%0d", i), 32'(busy[i]),               32'(e.busy[i]));
      check($sformatf("cnt%0d", i),  32'(fire_count[i*CW +: CW]), 32'(e.cnt[i*CW +: CW]));
      if (fire[i] === 1'b1) tally_fire[i]++;
      if (busy[i] === 1'b1) tally_busy[i]++;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_tally();
    for (int i = 0; i < CH; i++) begin
      tally_fire[i] = 0;
      tally_busy[i] = 0;
    end
  endtask

  task automatic set_val(input int ch, input int v);
    value[ch*W +: W] = W'(v);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_res[i] = 0; m_cnt[i] = 0; m_left[i] = 0; m_fire[i] = 0; m_wait[i] = 0;
    end
    clr_tally();
    reset = 1'b1; value = '0; match = '0; load = '0;
    mode = '0; enable = '0; clear = '0;
    match[0*W +: W] = 4'd3; load[0*W +: W] = 4'd3;
    match[1*W +: W] = 4'd5; load[1*W +: W] = 4'd9;
    match[2*W +: W] = 4'd7; load[2*W +: W] = 4'd6;
    value[2*W +: W] = 4'd7;
    steps(2);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    reset = 1'b0;
    enable = 4'b0011;

    // Basic wait: no fire until value reaches the match
    clr_tally();
    for (int v = 0; v < 3; v++) begin
      set_val(0, v);
      steps(2);
    end
    check("basic_nofire", 32'(tally_fire[0]), 32'd0);
    check("basic_res0",   32'(result[3:0]),   32'd0);
    set_val(0, 3);
    step();
    check("basic_fire", 32'(fire[0]),       32'd1);
    check("basic_res",  32'(result[3:0]),   32'd3);
    check("basic_cnt",  32'(fire_count[1:0]), 32'd1);
    set_val(0, 0);
    steps(4);

    // Level re-fire: 12 cycles of cond -> pulses every HOLD+1
    clear[0] = 1'b1; step(); clear[0] = 1'b0;
    clr_tally();
    set_val(0, 3);
    steps(12);
    check("lvl_fires", 32'(tally_fire[0]), 32'd3);
    check("lvl_busy",  32'(tally_busy[0]), 32'd9);
    check("lvl_cnt",   32'(fire_count[1:0]), 32'd3);
    set_val(0, 0);
    steps(4);

    // Edge mode: one fire per assertion
    clear[0] = 1'b1; step(); clear[0] = 1'b0;
    mode[0] = 1'b1;
    clr_tally();
    set_val(0, 3);
    steps(12);
    check("edge_one", 32'(tally_fire[0]), 32'd1);
    set_val(0, 0);
    step();
    set_val(0, 3);
    steps(6);
    check("edge_two", 32'(tally_fire[0]), 32'd2);
    check("edge_cnt", 32'(fire_count[1:0]), 32'd2);
    set_val(0, 0);
    steps(5);
    mode[0] = 1'b0;

    // Clear beats cond; reset mid-hold
    set_val(0, 3);
    clear[0] = 1'b1;
    step();
    check("clr_fire", 32'(fire[0]),         32'd0);
    check("clr_res",  32'(result[3:0]),     32'd0);
    check("clr_cnt",  32'(fire_count[1:0]), 32'd0);
    clear[0] = 1'b0;
    step();
    check("clr_refire", 32'(fire[0]), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_busy", 32'(busy[0]),        32'd0);
    check("rst_mid_res",  32'(result[3:0]),    32'd0);
    check("rst_mid_fire", 32'(fire[0]),        32'd0);
    reset = 1'b0;
    step();
    check("rst_then_fire", 32'(fire[0]), 32'd1);

    // Saturation on ch0, independence of ch1/ch2
    clear = '1; step(); clear = '0;
    clr_tally();
    set_val(0, 3);
    for (int k = 0; k < 20; k++) begin
      set_val(1, (k == 5 || k == 12) ? 5 : 0);
      step();
    end
    check("sat_cnt",    32'(fire_count[1:0]),  32'd3);
    check("sat_fires",  32'(tally_fire[0]),    32'd5);
    check("ind1_fires", 32'(tally_fire[1]),    32'd2);
    check("ind1_res",   32'(result[7:4]),      32'd9);
    check("ind2_fires", 32'(tally_fire[2]),    32'd0);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < CH; i++) begin
        value[i*W +: W] = W'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) mode[i] = ~mode[i];
        enable[i] = ($urandom_range(0, 5) != 0);
        clear[i]  = ($urandom_range(0, 19) == 0);
      end
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
